// File: rtl/soe_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : soe_accumulator
// Description : Per-bit sum-of-errors counter comparing a DUT against its
//               golden copy over a programmed number of samples.
// Revision    : 1.0  initial release
// ============================================================================
module soe_accumulator #(
   parameter int NUM_OUT = 2,
   parameter int CNT_W   = 32,
   parameter int CYC_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CYC_W-1:0]         max_cycles,
   input  logic                     sample_en,
   input  logic [NUM_OUT-1:0]       dut_out,
   input  logic [NUM_OUT-1:0]       golden_out,
   output logic                     busy,
   output logic                     done,
   output logic [CYC_W-1:0]         cycle_cnt,
   output logic [NUM_OUT*CNT_W-1:0] soe,
   output logic                     any_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_sat = '1;
   localparam logic [CYC_W-1:0] c_one = CYC_W'(1);

   state_t                     r_state;
   logic [CYC_W-1:0]           r_max;
   logic [CYC_W-1:0]           r_cycle_cnt;
   logic [NUM_OUT-1:0]         r_stage_mm;
   logic                       r_stage_vld;
   logic [NUM_OUT*CNT_W-1:0]   r_soe;
   logic                       r_any_err;
   logic                       r_busy;
   logic                       r_done;

   logic w_start_ok;
   logic w_last;

   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last     = (r_cycle_cnt == (r_max - c_one));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_max       <= '0;
         r_cycle_cnt <= '0;
         r_stage_mm  <= '0;
         r_stage_vld <= 1'b0;
         r_soe       <= '0;
         r_any_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // Retire the staged compare; counters stick at full scale.
         if (r_stage_vld) begin
            for (int i = 0; i < NUM_OUT; i++) begin
               if (r_soe[i*CNT_W +: CNT_W] != c_sat)
                  r_soe[i*CNT_W +: CNT_W] <= r_soe[i*CNT_W +: CNT_W] +
                                             {{(CNT_W-1){1'b0}}, r_stage_mm[i]};
            end
            if (|r_stage_mm)
               r_any_err <= 1'b1;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_soe       <= '0;
                  r_cycle_cnt <= '0;
                  r_any_err   <= 1'b0;
                  r_max       <= max_cycles;
                  r_stage_vld <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_state     <= (max_cycles == '0) ? S_DRAIN : S_RUN;
               end else if (r_state == S_DONE) begin
                  // busy/done trail the state by one edge, so done rises
                  // two edges after the final sample.
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
            S_RUN: begin
               if (sample_en) begin
                  r_stage_mm  <= dut_out ^ golden_out;
                  r_stage_vld <= 1'b1;
                  r_cycle_cnt <= r_cycle_cnt + c_one;
                  if (w_last)
                     r_state <= S_DRAIN;
               end else begin
                  r_stage_vld <= 1'b0;
               end
            end
            S_DRAIN: begin
               r_stage_vld <= 1'b0;
               r_state     <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign cycle_cnt = r_cycle_cnt;
   assign soe       = r_soe;
   assign any_err   = r_any_err;

endmodule
`default_nettype wire

// File: tb/tb_soe_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_soe_accumulator
// Description : Randomized campaigns checked against a sample-history model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_soe_accumulator;

   localparam int NUM_OUT = 2;
   localparam int CNT_W   = 4;
   localparam int CYC_W   = 16;
   localparam int SAT     = (1 << CNT_W) - 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [CYC_W-1:0]         max_cycles;
   logic                     sample_en;
   logic [NUM_OUT-1:0]       dut_out;
   logic [NUM_OUT-1:0]       golden_out;
   logic                     busy;
   logic                     done;
   logic [CYC_W-1:0]         cycle_cnt;
   logic [NUM_OUT*CNT_W-1:0] soe;
   logic                     any_err;

   int n_checks = 0;
   int n_errors = 0;

   // Mismatch vector of every sample taken in the current campaign, in order.
   logic [NUM_OUT-1:0] hist [$];

   soe_accumulator #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .CYC_W(CYC_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .max_cycles (max_cycles),
      .sample_en  (sample_en),
      .dut_out    (dut_out),
      .golden_out (golden_out),
      .busy       (busy),
      .done       (done),
      .cycle_cnt  (cycle_cnt),
      .soe        (soe),
      .any_err    (any_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected soe after the first n samples have been accumulated.
   function automatic logic [NUM_OUT*CNT_W-1:0] model_soe(input int n);
      logic [NUM_OUT*CNT_W-1:0] r = '0;
      for (int b = 0; b < NUM_OUT; b++) begin
         int cnt = 0;
         for (int k = 0; k < n; k++) cnt += int'(hist[k][b]);
         if (cnt > SAT) cnt = SAT;
         r[b*CNT_W +: CNT_W] = CNT_W'(cnt);
      end
      return r;
   endfunction

   function automatic logic model_err(input int n);
      for (int k = 0; k < n; k++)
         if (hist[k] != '0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int n_ret, input int n_cnt,
                            input logic exp_busy, input logic exp_done);
      check_eq({tag, ".soe"},  32'(soe),       32'(model_soe(n_ret)));
      check_eq({tag, ".cnt"},  32'(cycle_cnt), 32'(n_cnt));
      check_eq({tag, ".err"},  32'(any_err),   32'(model_err(n_ret)));
      check_eq({tag, ".busy"}, 32'(busy),      32'(exp_busy));
      check_eq({tag, ".done"}, 32'(done),      32'(exp_done));
   endtask

   // mode 0 random, 1 fixed pattern, 2 gated constant bit1 error, 3 constant bit0 error
   task automatic run_campaign(input int mode, input int max);
      logic [NUM_OUT-1:0] t2_dut [4];
      logic               t3_en  [5];
      int prev;
      int it;
      t2_dut = '{2'b01, 2'b11, 2'b00, 2'b01};
      t3_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      hist.delete();
      start      = 1'b1;
      max_cycles = CYC_W'(max);
      sample_en  = 1'($urandom);
      dut_out    = NUM_OUT'($urandom);
      golden_out = NUM_OUT'($urandom);
      step;
      start = 1'b0;
      check_all("start", 0, 0, 1'b1, 1'b0);
      it = 0;
      while (hist.size() < max && it < 500) begin
         golden_out = NUM_OUT'($urandom);
         case (mode)
            1: begin sample_en = 1'b1; golden_out = '0; dut_out = t2_dut[it % 4]; end
            2: begin sample_en = t3_en[it % 5]; dut_out = golden_out ^ 2'b10; end
            3: begin sample_en = 1'b1; dut_out = golden_out ^ 2'b01; end
            default: begin
               sample_en = ($urandom_range(0, 3) != 0);
               dut_out   = NUM_OUT'($urandom);
            end
         endcase
         start      = ($urandom_range(0, 7) == 0);
         max_cycles = CYC_W'($urandom);
         prev = hist.size();
         step;
         if (sample_en) hist.push_back(dut_out ^ golden_out);
         check_all("run", prev, hist.size(), 1'b1, 1'b0);
         it++;
      end
      check_eq("samples", 32'(hist.size()), 32'(max));
      start      = 1'($urandom);
      max_cycles = CYC_W'($urandom);
      sample_en  = 1'($urandom);
      dut_out    = NUM_OUT'($urandom);
      step;
      check_all("drain", hist.size(), hist.size(), 1'b1, 1'b0);
      start = 1'b0;
      for (int h = 0; h < 3; h++) begin
         sample_en  = 1'($urandom);
         dut_out    = NUM_OUT'($urandom);
         golden_out = NUM_OUT'($urandom);
         step;
         check_all("done", hist.size(), hist.size(), 1'b0, 1'b1);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      max_cycles = '0;
      sample_en  = 1'b0;
      dut_out    = '0;
      golden_out = '0;
      hist.delete();
      step;
      step;
      check_all("reset", 0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      step;

      run_campaign(1, 4);
      check_eq("t2.soe", 32'(soe), 32'h13);
      check_eq("t2.cnt", 32'(cycle_cnt), 32'd4);
      check_eq("t2.err", 32'(any_err), 32'd1);

      run_campaign(2, 3);
      check_eq("t3.soe", 32'(soe), 32'h30);
      check_eq("t3.cnt", 32'(cycle_cnt), 32'd3);

      run_campaign(0, 0);
      check_eq("t4.soe", 32'(soe), 32'h00);
      check_eq("t4.err", 32'(any_err), 32'd0);

      run_campaign(3, 20);
      check_eq("t5.soe", 32'(soe), 32'h0F);
      check_eq("t5.cnt", 32'(cycle_cnt), 32'd20);

      // Asynchronous reset in the middle of a campaign.
      start      = 1'b1;
      max_cycles = CYC_W'(10);
      step;
      start      = 1'b0;
      sample_en  = 1'b1;
      golden_out = 2'b00;
      dut_out    = 2'b01;
      repeat (4) step;
      check_eq("t1.pre_soe", 32'(soe), 32'h03);
      #2 rst = 1'b1;
      #1;
      hist.delete();
      check_all("t1.async", 0, 0, 1'b0, 1'b0);
      step;
      rst = 1'b0;
      repeat (3) step;
      check_all("t1.after", 0, 0, 1'b0, 1'b0);
      sample_en = 1'b0;

      for (int c = 0; c < 20; c++)
         run_campaign(0, $urandom_range(1, 40));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
